// File: rtl/player_motion_ctrl.sv
// Decodes PS/2 set-2 arrow/WASD scan codes into held-direction flags and steps
// player 0's sprite position once per frame, clamped to stay fully on screen.
module player_motion_ctrl #(
    parameter int unsigned H_RES  = 640,
    parameter int unsigned V_RES  = 480,
    parameter int unsigned SIZE   = 32,
    parameter int unsigned STEP   = 2,
    parameter int unsigned X_INIT = 304,
    parameter int unsigned Y_INIT = 224
) (
    input  logic        iVGA_CLK,
    input  logic        reset,
    input  logic [7:0]  ps2_key_data_in,
    input  logic        ps2_key_pressed,
    input  logic        iVS,
    output logic [31:0] player0_x,
    output logic [31:0] player0_y,
    output logic [1:0]  facing
);

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } dec_state_e;

    localparam logic [10:0] STEP_W = 11'(STEP);
    localparam logic [10:0] X_MAX  = 11'(H_RES - SIZE);
    localparam logic [10:0] Y_MAX  = 11'(V_RES - SIZE);
    localparam logic [10:0] X_RST  = 11'(X_INIT);
    localparam logic [10:0] Y_RST  = 11'(Y_INIT);

    localparam logic [1:0] FACE_RIGHT = 2'd0;
    localparam logic [1:0] FACE_LEFT  = 2'd1;
    localparam logic [1:0] FACE_UP    = 2'd2;
    localparam logic [1:0] FACE_DOWN  = 2'd3;

    dec_state_e  state_q, state_d;
    logic [3:0]  keys_q, keys_d;     // {up, down, left, right}
    logic        vs_q, vs_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic [1:0]  facing_q, facing_d;

    logic [3:0]  plain_dir, ext_dir;
    logic [3:0]  set_mask, clr_mask;
    logic        tick;
    logic [10:0] x_sum, y_sum;
    logic        key_up, key_down, key_left, key_right;

    always_comb begin
        plain_dir = '0;
        case (ps2_key_data_in)
            8'h1D:   plain_dir = 4'b1000;
            8'h1B:   plain_dir = 4'b0100;
            8'h1C:   plain_dir = 4'b0010;
            8'h23:   plain_dir = 4'b0001;
            default: plain_dir = '0;
        endcase
    end

    always_comb begin
        ext_dir = '0;
        case (ps2_key_data_in)
            8'h75:   ext_dir = 4'b1000;
            8'h72:   ext_dir = 4'b0100;
            8'h6B:   ext_dir = 4'b0010;
            8'h74:   ext_dir = 4'b0001;
            default: ext_dir = '0;
        endcase
    end

    always_ff @(posedge iVGA_CLK) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ps2_key_pressed) begin
            unique case (state_q)
                IDLE: begin
                    if (ps2_key_data_in == 8'hE0) begin
                        state_d = EXT;
                    end else if (ps2_key_data_in == 8'hF0) begin
                        state_d = BRK;
                    end else begin
                        state_d = IDLE;
                    end
                end
                EXT:     state_d = (ps2_key_data_in == 8'hF0) ? EXT_BRK : IDLE;
                BRK:     state_d = IDLE;
                EXT_BRK: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (ps2_key_pressed) begin
            unique case (state_q)
                IDLE:    set_mask = plain_dir;
                EXT:     set_mask = ext_dir;
                BRK:     clr_mask = plain_dir;
                EXT_BRK: clr_mask = ext_dir;
            endcase
        end
    end

    assign keys_d    = (keys_q | set_mask) & ~clr_mask;
    assign vs_d      = iVS;
    assign tick      = vs_q & ~iVS;
    assign key_up    = keys_q[3];
    assign key_down  = keys_q[2];
    assign key_left  = keys_q[1];
    assign key_right = keys_q[0];
    assign x_sum     = x_q + STEP_W;
    assign y_sum     = y_q + STEP_W;

    // Vertical is evaluated last so it owns facing when both axes move.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        facing_d = facing_q;
        if (tick) begin
            if (key_left && !key_right) begin
                x_d      = (x_q < STEP_W) ? '0 : x_q - STEP_W;
                facing_d = FACE_LEFT;
            end else if (key_right && !key_left) begin
                x_d      = (x_sum > X_MAX) ? X_MAX : x_sum;
                facing_d = FACE_RIGHT;
            end
            if (key_up && !key_down) begin
                y_d      = (y_q < STEP_W) ? '0 : y_q - STEP_W;
                facing_d = FACE_UP;
            end else if (key_down && !key_up) begin
                y_d      = (y_sum > Y_MAX) ? Y_MAX : y_sum;
                facing_d = FACE_DOWN;
            end
        end
    end

    always_ff @(posedge iVGA_CLK) begin
        if (reset) begin
            keys_q   <= '0;
            vs_q     <= 1'b1;
            x_q      <= X_RST;
            y_q      <= Y_RST;
            facing_q <= FACE_RIGHT;
        end else begin
            keys_q   <= keys_d;
            vs_q     <= vs_d;
            x_q      <= x_d;
            y_q      <= y_d;
            facing_q <= facing_d;
        end
    end

    assign player0_x = {21'd0, x_q};
    assign player0_y = {21'd0, y_q};
    assign facing    = facing_q;

endmodule
